measure_block_mc: RTL

- Parametrised successor of the memory-checker measurement block. Passively snoops one Avalon-MM master port and accumulates write throughput, read throughput and first-word read latency statistics.
- Read latency is tracked with a timestamp FIFO of configurable depth, so many overlapping bursts can be in flight.
- Adds a latency histogram, saturating counters and sticky error flags.
- Sits beside the traffic generator; the CSR block reads the results.

---
 rtl/rtl_settings_pkg.sv | 18 +
 rtl/rd_lat_tracker.sv | 58 +++++
 rtl/measure_block_mc.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rtl_settings_pkg.sv
// rtl_settings_pkg: shared error-flag indices, bus width defaults and counting helpers
package rtl_settings_pkg;
  localparam int ERR_OVF = 0;
  localparam int ERR_ORPHAN = 1;
  localparam int AMM_BURST_W_DEF = 11;
  localparam int AMM_DATA_B_W_DEF = 16;
  function automatic logic [3:0] bytes_count(input logic [7:0] be);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c += 4'(be[i]);
    return c;
  endfunction
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction
endpackage

// File: rtl/rd_lat_tracker.sv
// rd_lat_tracker: timestamp FIFO of outstanding read bursts, yields first-beat latency
module rd_lat_tracker #(
  parameter int AMM_BURST_W = 11,
  parameter int DELAY_W = 16,
  parameter int OUTSTD_NUM = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   i_push,
  input  logic [DELAY_W:0]       i_ts,
  input  logic [AMM_BURST_W-1:0] i_bc,
  input  logic                   i_beat,
  output logic                   o_lat_vld,
  output logic [DELAY_W-1:0]     o_lat,
  output logic                   o_empty,
  output logic                   o_ovf,
  output logic                   o_orphan
);
  localparam int PW = $clog2(OUTSTD_NUM);
  logic [DELAY_W:0]       r_ts_mem [OUTSTD_NUM];
  logic [AMM_BURST_W-1:0] r_bc_mem [OUTSTD_NUM];
  logic [PW-1:0]          r_wp, r_rp;
  logic [PW:0]            r_cnt;
  logic [AMM_BURST_W-1:0] r_beats;
  logic                   w_full, w_act, w_pop, w_wr;
  logic [DELAY_W:0]       w_hd_ts, w_diff;
  logic [AMM_BURST_W-1:0] w_hd_bc;
  assign o_empty = r_cnt == '0;
  assign w_full = r_cnt == (PW+1)'(OUTSTD_NUM);
  // an empty FIFO lets a beat land on the entry being pushed in the same cycle
  assign w_hd_ts = o_empty ? i_ts : r_ts_mem[r_rp];
  assign w_hd_bc = o_empty ? i_bc : r_bc_mem[r_rp];
  assign w_act = i_beat && (!o_empty || i_push);
  assign w_pop = w_act && ({1'b0, r_beats} + {{AMM_BURST_W{1'b0}}, 1'b1} >= {1'b0, w_hd_bc});
  assign w_wr = i_push && (!w_full || w_pop);
  assign w_diff = i_ts - w_hd_ts;
  assign o_lat = w_diff[DELAY_W] ? '1 : (w_diff[DELAY_W-1:0] == '0 ? DELAY_W'(1) : w_diff[DELAY_W-1:0]);
  assign o_lat_vld = w_act && r_beats == '0;
  assign o_ovf = i_push && !w_wr;
  assign o_orphan = i_beat && o_empty && !i_push;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_beats <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(w_wr) - (PW+1)'(w_pop);
      r_beats <= w_pop ? '0 : w_act ? r_beats + AMM_BURST_W'(1) : r_beats;
    end
  always_ff @(posedge clk_i)
    if (w_wr) begin
      r_ts_mem[r_wp] <= i_ts;
      r_bc_mem[r_wp] <= i_bc;
    end
endmodule

// File: rtl/measure_block_mc.sv
// measure_block_mc: passive Avalon-MM snoop collecting throughput, latency and histogram stats
module measure_block_mc import rtl_settings_pkg::*; #(
  parameter int AMM_BURST_W = AMM_BURST_W_DEF,
  parameter int DATA_B_W = AMM_DATA_B_W_DEF,
  parameter     ADDR_TYPE = "BYTE",
  parameter int OUTSTD_NUM = 8,
  parameter int DELAY_W = 16,
  parameter int HIST_BINS = 16,
  parameter int HIST_SHIFT = 2,
  parameter int SUM_W = 48
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         readdatavalid_i,
  input  logic                         waitrequest_i,
  input  logic                         read_i,
  input  logic                         write_i,
  input  logic [AMM_BURST_W-1:0]       burstcount_i,
  input  logic [DATA_B_W-1:0]          byteenable_i,
  input  logic                         test_start_i,
  input  logic [$clog2(HIST_BINS)-1:0] hist_sel_i,
  output logic [31:0]                  hist_cnt_o,
  output logic                         meas_busy_o,
  output logic [31:0]                  wr_ticks_o,
  output logic [31:0]                  wr_units_o,
  output logic [31:0]                  rd_ticks_o,
  output logic [31:0]                  rd_words_o,
  output logic [31:0]                  rd_req_o,
  output logic [DELAY_W-1:0]           min_delay_o,
  output logic [DELAY_W-1:0]           max_delay_o,
  output logic [SUM_W-1:0]             sum_delay_o,
  output logic [1:0]                   err_flags_o
);
  localparam int HW = $clog2(HIST_BINS);
  logic [DELAY_W:0]   r_ts;
  logic               r_rd_pend;
  logic               w_lat_vld, w_empty, w_ovf, w_orphan, w_wr_acc;
  logic               w_units_vld, w_wr_pipe;
  logic [31:0]        w_units;
  logic [DELAY_W-1:0] w_lat, w_shift;
  logic [HW-1:0]      w_bin;
  logic [SUM_W:0]     w_sum_n;
  logic [31:0]        r_wr_ticks, r_wr_units, r_rd_ticks, r_rd_words, r_rd_req, r_hist_cnt;
  logic [1:0]         r_err;
  logic               r_s1_vld;
  logic [DELAY_W-1:0] r_s1_lat, r_min, r_max;
  logic [SUM_W-1:0]   r_sum;
  logic [31:0]        r_hist [HIST_BINS];
  assign w_wr_acc = write_i && !waitrequest_i;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_ts <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_ts <= r_ts + (DELAY_W+1)'(1);
      r_rd_pend <= read_i && waitrequest_i;
    end
  rd_lat_tracker #(
    .AMM_BURST_W(AMM_BURST_W),
    .DELAY_W(DELAY_W),
    .OUTSTD_NUM(OUTSTD_NUM)
  ) u_trk (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .i_push(read_i && !r_rd_pend),
    .i_ts(r_ts),
    .i_bc(burstcount_i),
    .i_beat(readdatavalid_i),
    .o_lat_vld(w_lat_vld),
    .o_lat(w_lat),
    .o_empty(w_empty),
    .o_ovf(w_ovf),
    .o_orphan(w_orphan)
  );
  if (ADDR_TYPE == "BYTE") begin : g_byte
    localparam int G = DATA_B_W > 8 ? DATA_B_W / 8 : 1;
    localparam int LV = $clog2(G);
    localparam int CW = $clog2(DATA_B_W + 1);
    logic [G*8-1:0] w_be;
    logic [CW-1:0]  r_tree [LV+1][G];
    logic [LV:0]    r_tv;
    assign w_be = (G*8)'(byteenable_i);
    // first level counts each 8-byte lane, later levels pairwise-add lanes
    always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
        r_tv <= '0;
        r_tree <= '{default: '{default: '0}};
      end else begin
        r_tv <= test_start_i ? '0 : (r_tv << 1) | (LV+1)'(w_wr_acc);
        for (int g = 0; g < G; g++) r_tree[0][g] <= w_wr_acc ? CW'(bytes_count(w_be[g*8 +: 8])) : '0;
        for (int l = 1; l <= LV; l++)
          for (int g = 0; g < (G >> l); g++) r_tree[l][g] <= r_tree[l-1][2*g] + r_tree[l-1][2*g+1];
      end
    assign w_units_vld = r_tv[LV];
    assign w_units = 32'(r_tree[LV][0]);
    assign w_wr_pipe = |r_tv;
  end else begin : g_word
    assign w_units_vld = w_wr_acc;
    assign w_units = 32'd1;
    assign w_wr_pipe = 1'b0;
  end
  assign w_shift = r_s1_lat >> HIST_SHIFT;
  assign w_bin = w_shift >= DELAY_W'(HIST_BINS) ? HW'(HIST_BINS - 1) : HW'(w_shift);
  assign w_sum_n = {1'b0, r_sum} + (SUM_W+1)'(r_s1_lat);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_wr_ticks <= '0;
      r_wr_units <= '0;
      r_rd_ticks <= '0;
      r_rd_words <= '0;
      r_rd_req <= '0;
      r_err <= '0;
    end else if (test_start_i) begin
      r_wr_ticks <= '0;
      r_wr_units <= '0;
      r_rd_ticks <= '0;
      r_rd_words <= '0;
      r_rd_req <= '0;
      r_err <= '0;
    end else begin
      if (write_i) r_wr_ticks <= sat_add(r_wr_ticks, 32'd1);
      if (w_units_vld) r_wr_units <= sat_add(r_wr_units, w_units);
      if (!w_empty) r_rd_ticks <= sat_add(r_rd_ticks, 32'd1);
      if (readdatavalid_i) r_rd_words <= sat_add(r_rd_words, 32'd1);
      if (read_i && !waitrequest_i) r_rd_req <= sat_add(r_rd_req, 32'd1);
      if (w_ovf) r_err[ERR_OVF] <= 1'b1;
      if (w_orphan) r_err[ERR_ORPHAN] <= 1'b1;
    end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_s1_vld <= 1'b0;
      r_s1_lat <= '0;
      r_min <= '1;
      r_max <= '0;
      r_sum <= '0;
      r_hist_cnt <= '0;
      for (int i = 0; i < HIST_BINS; i++) r_hist[i] <= '0;
    end else if (test_start_i) begin
      r_s1_vld <= 1'b0;
      r_min <= '1;
      r_max <= '0;
      r_sum <= '0;
      r_hist_cnt <= '0;
      for (int i = 0; i < HIST_BINS; i++) r_hist[i] <= '0;
    end else begin
      r_s1_vld <= w_lat_vld;
      r_s1_lat <= w_lat;
      r_hist_cnt <= r_hist[hist_sel_i];
      if (r_s1_vld) begin
        r_min <= r_s1_lat < r_min ? r_s1_lat : r_min;
        r_max <= r_s1_lat > r_max ? r_s1_lat : r_max;
        r_sum <= w_sum_n[SUM_W] ? '1 : w_sum_n[SUM_W-1:0];
        r_hist[w_bin] <= sat_add(r_hist[w_bin], 32'd1);
      end
    end
  assign hist_cnt_o = r_hist_cnt;
  assign meas_busy_o = !w_empty || r_s1_vld || w_wr_pipe;
  assign wr_ticks_o = r_wr_ticks;
  assign wr_units_o = r_wr_units;
  assign rd_ticks_o = r_rd_ticks;
  assign rd_words_o = r_rd_words;
  assign rd_req_o = r_rd_req;
  assign min_delay_o = r_min;
  assign max_delay_o = r_max;
  assign sum_delay_o = r_sum;
  assign err_flags_o = r_err;
endmodule
